man_alu_arbiter: RTL and testbench

- Shares one mantissa add/sub datapath (the existing MAN_ALU, SIZE_MAN-bit CLA) between NUM_REQ requesters, e.g. two FPU add/sub lanes.
- Round-robin arbitration with valid/ready handshakes on the request side.
- Two-stage pipeline: the issue register drives the ALU; the result register captures ALU output plus requester ID.
- Full-throughput (1 op/cycle) with backpressure from the result consumer.

---
 rtl/fpu_pkg.sv | 13 +
 rtl/MAN_ALU.sv | 27 ++
 rtl/rr_arbiter.sv | 26 ++
 rtl/man_alu_arbiter.sv | 102 ++++++++++
 tb/tb_man_alu_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared mantissa request type, default width and op encodings.
package fpu_pkg;
    localparam int SIZE_MAN_DEF = 28;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    typedef struct packed {
        logic                    op;
        logic                    sign_a;
        logic                    sign_b;
        logic [SIZE_MAN_DEF-1:0] man_max;
        logic [SIZE_MAN_DEF-1:0] man_min;
    } man_req_t;
endpackage

// File: rtl/MAN_ALU.sv
// MAN_ALU: mantissa add/sub, NUM_OP independent lanes; effective sub is
// max + ~min + 1, carry out reported only on effective add.
module MAN_ALU
    import fpu_pkg::*;
#(
    parameter int NUM_OP   = 1,
    parameter int SIZE_MAN = SIZE_MAN_DEF
) (
    input  logic [NUM_OP-1:0]          op_i,
    input  logic [NUM_OP-1:0]          sign_a_i,
    input  logic [NUM_OP-1:0]          sign_b_i,
    input  logic [NUM_OP*SIZE_MAN-1:0] man_max_i,
    input  logic [NUM_OP*SIZE_MAN-1:0] man_min_i,
    output logic [NUM_OP*SIZE_MAN-1:0] man_o,
    output logic [NUM_OP-1:0]          overflow_o
);
    for (genvar g = 0; g < NUM_OP; g++) begin : g_op
        logic                eff_sub;
        logic [SIZE_MAN-1:0] b;
        logic [SIZE_MAN:0]   sum;
        assign eff_sub = (op_i[g] == OP_SUB) ^ sign_a_i[g] ^ sign_b_i[g];
        assign b = eff_sub ? ~man_min_i[g*SIZE_MAN +: SIZE_MAN] : man_min_i[g*SIZE_MAN +: SIZE_MAN];
        assign sum = {1'b0, man_max_i[g*SIZE_MAN +: SIZE_MAN]} + {1'b0, b} + {{SIZE_MAN{1'b0}}, eff_sub};
        assign man_o[g*SIZE_MAN +: SIZE_MAN] = sum[SIZE_MAN-1:0];
        assign overflow_o[g] = !eff_sub && sum[SIZE_MAN];
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr_i; the pointer
// state lives in the parent.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);
    logic found;
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[(int'(ptr_i) + i) % NUM_REQ]) begin
                found = 1'b1;
                idx_o = ID_W'((int'(ptr_i) + i) % NUM_REQ);
            end
        end
        gnt_o[idx_o] = found && en_i;
    end
endmodule

// File: rtl/man_alu_arbiter.sv
// man_alu_arbiter: round-robin sharing of one MAN_ALU between NUM_REQ
// requesters through an issue register and a result register.
module man_alu_arbiter
    import fpu_pkg::*;
#(
    parameter  int NUM_REQ  = 2,
    parameter  int SIZE_MAN = SIZE_MAN_DEF,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    output logic [NUM_REQ-1:0]          o_req_ready,
    input  logic [NUM_REQ-1:0]          i_req_op,
    input  logic [NUM_REQ-1:0]          i_req_sign_a,
    input  logic [NUM_REQ-1:0]          i_req_sign_b,
    input  logic [NUM_REQ*SIZE_MAN-1:0] i_req_man_max,
    input  logic [NUM_REQ*SIZE_MAN-1:0] i_req_man_min,
    output logic                        o_res_valid,
    input  logic                        i_res_ready,
    output logic [ID_W-1:0]             o_res_id,
    output logic [SIZE_MAN-1:0]         o_res_man,
    output logic                        o_res_overflow,
    output logic                        o_busy
);
    logic                iss_vld_q, iss_op_q, iss_sa_q, iss_sb_q;
    logic [SIZE_MAN-1:0] iss_max_q, iss_min_q;
    logic [ID_W-1:0]     iss_id_q, rr_ptr_q, rr_ptr_d, gnt_idx;
    logic                res_vld_q, res_ovf_q;
    logic [SIZE_MAN-1:0] res_man_q, alu_man;
    logic [ID_W-1:0]     res_id_q;
    logic [NUM_REQ-1:0]  gnt;
    logic                res_adv, iss_adv, accept, alu_ovf;

    assign res_adv     = !res_vld_q || i_res_ready;
    assign iss_adv     = !iss_vld_q || res_adv;
    assign accept      = |gnt;
    assign o_req_ready = gnt;
    assign rr_ptr_d    = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

    // Grants are suppressed during reset so nothing is advertised as accepted.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i (i_req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (iss_adv && i_rst_n),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    MAN_ALU #(.NUM_OP(1), .SIZE_MAN(SIZE_MAN)) u_alu (
        .op_i       (iss_op_q),
        .sign_a_i   (iss_sa_q),
        .sign_b_i   (iss_sb_q),
        .man_max_i  (iss_max_q),
        .man_min_i  (iss_min_q),
        .man_o      (alu_man),
        .overflow_o (alu_ovf)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            iss_vld_q <= 1'b0;
            iss_op_q  <= 1'b0;
            iss_sa_q  <= 1'b0;
            iss_sb_q  <= 1'b0;
            iss_max_q <= '0;
            iss_min_q <= '0;
            iss_id_q  <= '0;
            rr_ptr_q  <= '0;
            res_vld_q <= 1'b0;
            res_man_q <= '0;
            res_ovf_q <= 1'b0;
            res_id_q  <= '0;
        end else begin
            if (iss_adv)
                iss_vld_q <= accept;
            if (accept) begin
                iss_op_q  <= i_req_op[gnt_idx];
                iss_sa_q  <= i_req_sign_a[gnt_idx];
                iss_sb_q  <= i_req_sign_b[gnt_idx];
                iss_max_q <= i_req_man_max[int'(gnt_idx)*SIZE_MAN +: SIZE_MAN];
                iss_min_q <= i_req_man_min[int'(gnt_idx)*SIZE_MAN +: SIZE_MAN];
                iss_id_q  <= gnt_idx;
                rr_ptr_q  <= rr_ptr_d;
            end
            if (res_adv) begin
                res_vld_q <= iss_vld_q;
                if (iss_vld_q) begin
                    res_man_q <= alu_man;
                    res_ovf_q <= alu_ovf;
                    res_id_q  <= iss_id_q;
                end
            end
        end
    end

    assign o_res_valid    = res_vld_q;
    assign o_res_id       = res_id_q;
    assign o_res_man      = res_man_q;
    assign o_res_overflow = res_ovf_q;
    assign o_busy         = iss_vld_q | res_vld_q;
endmodule

// File: tb/tb_man_alu_arbiter.sv
// tb_man_alu_arbiter: directed vectors with a result scoreboard for man_alu_arbiter.
module tb_man_alu_arbiter;
    import fpu_pkg::*;
    localparam int N = 2;
    localparam int W = 28;
    typedef struct packed {
        logic         id;
        logic [W-1:0] man;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n, res_ready, res_valid, res_id, res_ovf, busy;
    logic [N-1:0] vld, rdy, op, sa, sb;
    logic [N*W-1:0] mmax, mmin;
    logic [W-1:0] res_man;

    man_req_t     vr[9];
    logic [W-1:0] vm[9];
    logic         vo[9];
    int           cur[N];
    exp_t         q[$];
    exp_t         e_m;
    int           checks = 0, errors = 0, mchecks = 0, merrors = 0;

    always #5 clk = ~clk;

    man_alu_arbiter #(.NUM_REQ(N), .SIZE_MAN(W)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (vld),
        .o_req_ready    (rdy),
        .i_req_op       (op),
        .i_req_sign_a   (sa),
        .i_req_sign_b   (sb),
        .i_req_man_max  (mmax),
        .i_req_man_min  (mmin),
        .o_res_valid    (res_valid),
        .i_res_ready    (res_ready),
        .o_res_id       (res_id),
        .o_res_man      (res_man),
        .o_res_overflow (res_ovf),
        .o_busy         (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic o, input logic a, input logic b,
                        input logic [W-1:0] mx, input logic [W-1:0] mn,
                        input logic [W-1:0] m, input logic ov);
        vr[i] = '{op: o, sign_a: a, sign_b: b, man_max: mx, man_min: mn};
        vm[i] = m;
        vo[i] = ov;
    endtask

    task automatic drive(input int k, input int v);
        op[k] = vr[v].op;
        sa[k] = vr[v].sign_a;
        sb[k] = vr[v].sign_b;
        mmax[k*W +: W] = vr[v].man_max;
        mmin[k*W +: W] = vr[v].man_min;
        cur[k] = v;
    endtask

    task automatic tick(input logic [N-1:0] exp_rdy, input bit push);
        @(negedge clk);
        chk("req_ready", 32'(rdy), 32'(exp_rdy));
        for (int k = 0; k < N; k++)
            if (push && exp_rdy[k] && vld[k])
                q.push_back('{id: 1'(k), man: vm[cur[k]], ovf: vo[cur[k]]});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vld = '0;
        repeat (n) tick('0, 1'b0);
    endtask

    // Scoreboard monitor: every result handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            mchecks++;
            if (q.size() == 0) begin
                merrors++;
                $display("FAIL result_unexpected: got id %0d man %0h ovf %0d expected none", res_id, res_man, res_ovf);
            end else begin
                e_m = q.pop_front();
                if ({res_id, res_man, res_ovf} !== e_m) begin
                    merrors++;
                    $display("FAIL result: got id %0d man %0h ovf %0d expected id %0d man %0h ovf %0d",
                             res_id, res_man, res_ovf, e_m.id, e_m.man, e_m.ovf);
                end
            end
        end
    end

    initial begin
        setv(0, 1'b0, 1'b0, 1'b0, 28'h0C00000, 28'h0400000, 28'h1000000, 1'b0);
        setv(1, 1'b1, 1'b0, 1'b0, 28'h0C00000, 28'h0400000, 28'h0800000, 1'b0);
        setv(2, 1'b0, 1'b0, 1'b0, 28'hFFFFFFF, 28'h0000001, 28'h0000000, 1'b1);
        setv(3, 1'b0, 1'b1, 1'b0, 28'h0000010, 28'h0000003, 28'h000000D, 1'b0);
        setv(4, 1'b1, 1'b1, 1'b0, 28'h8000000, 28'h8000000, 28'h0000000, 1'b1);
        setv(5, 1'b0, 1'b1, 1'b1, 28'h1234567, 28'h0111111, 28'h1345678, 1'b0);
        setv(6, 1'b1, 1'b0, 1'b0, 28'h00ABCDE, 28'h00ABCDE, 28'h0000000, 1'b0);
        setv(7, 1'b1, 1'b0, 1'b1, 28'h0000005, 28'h0000007, 28'h000000C, 1'b0);
        setv(8, 1'b0, 1'b0, 1'b1, 28'hFFFFFFF, 28'h0000001, 28'hFFFFFFE, 1'b0);
        rst_n = 1'b0;
        res_ready = 1'b1;
        vld = 2'b11;
        drive(0, 0);
        drive(1, 1);
        repeat (3) begin
            @(negedge clk);
            chk("reset_ready", 32'(rdy), 0);
            chk("reset_res_valid", 32'(res_valid), 0);
            chk("reset_busy", 32'(busy), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2'b01, 1'b1);
        vld = 2'b10;
        tick(2'b10, 1'b1);
        drive(1, 2);
        tick(2'b10, 1'b1);
        // Both requesters valid: grants must alternate starting from 0.
        vld = 2'b11;
        for (int i = 0; i < 6; i++) begin
            drive(0, 3 + i % 3);
            drive(1, 8 - i % 3);
            tick((i % 2) ? 2'b10 : 2'b01, 1'b1);
        end
        idle(3);
        @(negedge clk);
        chk("drained_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        drive(0, 0);
        vld = 2'b01;
        tick(2'b01, 1'b1);
        res_ready = 1'b0;
        drive(0, 1);
        tick(2'b01, 1'b1);
        drive(0, 2);
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", 32'(rdy), 0);
            chk("stall_valid", 32'(res_valid), 1);
            chk("stall_man", 32'(res_man), 32'h1000000);
            chk("stall_id", 32'(res_id), 0);
            chk("stall_busy", 32'(busy), 1);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        tick(2'b01, 1'b1);
        idle(3);
        @(negedge clk);
        chk("bp_drained_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        vld = 2'b11;
        drive(0, 3);
        drive(1, 4);
        tick(2'b10, 1'b0);
        tick(2'b01, 1'b0);
        rst_n = 1'b0;
        vld = 2'b00;
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 1);
        chk("pre_reset_valid", 32'(res_valid), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midreset_valid", 32'(res_valid), 0);
        chk("midreset_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        vld = 2'b11;
        drive(0, 5);
        drive(1, 6);
        tick(2'b01, 1'b1);
        idle(4);
        @(negedge clk);
        chk("final_busy", 32'(busy), 0);
        chk("scoreboard_empty", 32'(q.size()), 0);
        checks += mchecks;
        errors += merrors;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
